// File: rtl/div_pkg.sv
// Shared definitions for the repeated-subtraction divider: state encoding and default width.
package div_pkg;

    localparam int W_DEFAULT = 16;

    localparam logic [2:0] ST_IDLE = 3'b000;
    localparam logic [2:0] ST_LDN  = 3'b001;
    localparam logic [2:0] ST_LDD  = 3'b010;
    localparam logic [2:0] ST_CALC = 3'b011;
    localparam logic [2:0] ST_DONE = 3'b100;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        LDN  = ST_LDN,
        LDD  = ST_LDD,
        CALC = ST_CALC,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/div_repsub_if.sv
// Divider request/result bundle; master drives start/data_in, slave returns results and status.
// Operands share data_in on consecutive cycles, so there is no per-operand handshake.
interface div_repsub_if
    import div_pkg::*;
#(
    parameter int W = W_DEFAULT
);
    logic         start;
    logic [W-1:0] data_in;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    modport master (
        output start, data_in,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, data_in,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/div_datapath.sv
// Divider datapath: remainder/divisor/quotient registers, guarded subtractor, compare, zero detect.
// Single-cycle register updates; no backpressure, controls are applied unconditionally.
module div_datapath
    import div_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] data_in,
    input  logic         ld_r,
    input  logic         ld_d,
    input  logic         sub,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         ge,
    output logic         zero
);
    logic [W-1:0] r_q;
    logic [W-1:0] d_q;
    logic [W-1:0] q_q;

    assign zero      = (data_in == '0);
    assign ge        = (r_q >= d_q);
    assign quotient  = q_q;
    assign remainder = r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
            d_q <= '0;
            q_q <= '0;
        end else begin
            if (ld_r) begin
                r_q <= data_in;
            end
            if (ld_d) begin
                d_q <= data_in;
                // A zero divisor saturates the quotient; the dividend stays as remainder.
                q_q <= zero ? '1 : '0;
            end
            if (sub) begin
                r_q <= r_q - d_q;
                q_q <= q_q + W'(1);
            end
        end
    end
endmodule

// File: rtl/div_repsub.sv
// Sequential unsigned divider by repeated subtraction; DONE is reached q+3 edges after start.
// No backpressure: start is only honoured in IDLE/DONE and results hold until the next start.
module div_repsub
    import div_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input logic         clk,
    input logic         rst,
    div_repsub_if.slave bus
);
    state_t state_q;
    state_t state_d;
    logic   ld_r;
    logic   ld_d;
    logic   sub;
    logic   ge;
    logic   zero;
    logic   dz_q;

    div_datapath #(.W(W)) u_dp (
        .clk       (clk),
        .rst       (rst),
        .data_in   (bus.data_in),
        .ld_r      (ld_r),
        .ld_d      (ld_d),
        .sub       (sub),
        .quotient  (bus.quotient),
        .remainder (bus.remainder),
        .ge        (ge),
        .zero      (zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ld_r    = 1'b0;
        ld_d    = 1'b0;
        sub     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = LDN;
                end
            end
            LDN: begin
                ld_r    = 1'b1;
                state_d = LDD;
            end
            LDD: begin
                ld_d    = 1'b1;
                state_d = zero ? DONE : CALC;
            end
            CALC: begin
                if (ge) begin
                    sub = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_d = LDN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dz_q <= 1'b0;
        end else if (ld_d) begin
            dz_q <= zero;
        end else if (state_q == DONE && bus.start) begin
            dz_q <= 1'b0;
        end
    end

    assign bus.busy        = (state_q == LDN) || (state_q == LDD) || (state_q == CALC);
    assign bus.done        = (state_q == DONE);
    assign bus.div_by_zero = (state_q == DONE) && dz_q;
endmodule

// File: tb/tb_div_repsub.sv
// Scoreboard bench for div_repsub: expected results queued at stimulus, compared when done rises.
module tb_div_repsub;
    import div_pkg::*;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t sb[$];

    div_repsub_if #(.W(W)) bus ();

    div_repsub #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.data_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.quotient !== 16'd0 || bus.remainder !== 16'd0) begin
            failures++;
            $display("FAIL reset_data q=%0d r=%0d required 0 0", bus.quotient, bus.remainder);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags busy=%b done=%b dz=%b required 0 0 0",
                     bus.busy, bus.done, bus.div_by_zero);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle busy=%b done=%b required 0 0", bus.busy, bus.done);
        end
    endtask

    // Drives one division from IDLE or DONE; the call starts just after a negedge.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit pulse, input string name);
        exp_t e;
        exp_t got;
        int   k;
        bit   seen;
        logic [W-1:0] q_hold;
        e.dz  = (b == 0);
        e.q   = (b == 0) ? 16'hFFFF : a / b;
        e.r   = (b == 0) ? a : a % b;
        e.lat = (b == 0) ? 2 : int'(e.q) + 3;
        sb.push_back(e);

        bus.start = 1'b1;
        @(negedge clk);
        k = 0;
        bus.start = 1'b0;
        bus.data_in = a;
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL %s_start busy=%b done=%b required 1 0", name, bus.busy, bus.done);
        end
        @(negedge clk);
        k = 1;
        bus.data_in = b;
        seen = 1'b0;
        while (k < 70000) begin
            @(negedge clk);
            k++;
            if (bus.done === 1'b1) begin
                bus.start = 1'b0;
                seen = 1'b1;
                break;
            end
            bus.start = pulse && (k >= 2) && k[0];
        end
        bus.start = 1'b0;

        got = sb.pop_front();
        checks++;
        if (!seen || k != got.lat) begin
            failures++;
            $display("FAIL %s_latency seen=%0b edge=%0d required edge %0d", name, seen, k, got.lat);
        end
        checks++;
        if (bus.quotient !== got.q || bus.remainder !== got.r) begin
            failures++;
            $display("FAIL %s_result q=%0d r=%0d required q=%0d r=%0d",
                     name, bus.quotient, bus.remainder, got.q, got.r);
        end
        checks++;
        if (bus.div_by_zero !== got.dz || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_flags dz=%b busy=%b required dz=%b busy=0",
                     name, bus.div_by_zero, bus.busy, got.dz);
        end
        q_hold = bus.quotient;
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || bus.quotient !== q_hold || bus.remainder !== got.r) begin
            failures++;
            $display("FAIL %s_hold done=%b q=%0d r=%0d required done=1 q=%0d r=%0d",
                     name, bus.done, bus.quotient, bus.remainder, q_hold, got.r);
        end
    endtask

    task automatic test_nominal();
        run_div(16'd100, 16'd7, 1'b0, "nominal");
    endtask

    task automatic test_zero_quotient();
        run_div(16'd5, 16'd9, 1'b0, "zero_quot");
    endtask

    task automatic test_div_by_zero();
        run_div(16'd42, 16'd0, 1'b0, "div_zero");
    endtask

    task automatic test_boundaries();
        run_div(16'd65535, 16'd65535, 1'b0, "max_by_max");
        run_div(16'd65535, 16'd1, 1'b0, "max_by_one");
    endtask

    task automatic test_start_pulses();
        run_div(16'd100, 16'd7, 1'b1, "start_pulse");
    endtask

    task automatic test_abort();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.data_in = 16'd100;
        @(negedge clk);
        bus.data_in = 16'd7;
        // CALC edges begin at E3, so the fifth one is E7.
        repeat (5) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_pre busy=%b required 1", bus.busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.quotient !== 16'd0 || bus.remainder !== 16'd0 || bus.busy !== 1'b0 ||
            bus.done !== 1'b0 || bus.div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL abort_clear q=%0d r=%0d busy=%b done=%b dz=%b required all 0",
                     bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle busy=%b done=%b required 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_back_to_back();
        run_div(16'd9, 16'd3, 1'b0, "after_abort");
        run_div(16'd10, 16'd4, 1'b0, "back_to_back");
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.data_in = '0;
        test_reset();
        test_nominal();
        test_zero_quotient();
        test_div_by_zero();
        test_start_pulses();
        test_abort();
        test_back_to_back();
        test_boundaries();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
